lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the RV32I core's memory stage and the word-addressed data memory.
- Data memory: synchronous write, combinational read, word writes only.
- Accepts one load or store at a time from the core and performs byte, halfword or word access with sign or zero extension.
- Implements sb/sh as read-modify-write over two memory cycles. Flags misaligned or illegal accesses instead of touching memory.

Parameters:
- XLEN, 32, data and address width. Fixed at 32 for RV32I.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  extended load data. 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned or illegal funct3.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory byte address, bits [1:0] always 0.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data (combinational from mem_addr).

Behaviour:
- Reset:
  - state=IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0, mem_addr=0, mem_wd=0.
  - All latched request fields cleared.
- Handshake:
  - Transfer when req_valid && req_ready. Latch we, funct3, addr, wdata at that edge.
  - req_ready = (state==IDLE) && !rst.
  - No response backpressure: the core must take resp_valid when it pulses.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Accept decode (transition out of IDLE):
  - Error → RESP with err flag:
    - illegal funct3: load 011/110/111, store anything other than 000/001/010;
    - halfword with addr[0]=1;
    - word with addr[1:0]≠0.
  - Load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_RD.
- LOAD:
  - mem_addr = {addr[31:2],2'b00}.
  - Select byte by addr[1:0] or halfword by addr[1].
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Register the result into resp_rdata → RESP.
- RMW_RD:
  - mem_addr = aligned addr. Capture mem_rd into merge register → WRITE.
- WRITE:
  - mem_we=1 for exactly one cycle.
  - mem_wd for SW = wdata.
  - mem_wd for SB/SH = merge word with only the addressed byte or halfword replaced by wdata[7:0] or wdata[15:0].
  - → RESP.
- RESP:
  - resp_valid=1 for one cycle, resp_err per decode → IDLE.
  - resp_rdata holds its value until the next response.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles;
  - error: 1 cycle.
- mem_we is low in every state except WRITE. mem_addr and mem_wd are 0 in IDLE and RESP.
- mem_we is gated by !rst: asserting rst during WRITE suppresses the write at that edge.
- Reset mid-operation aborts the transaction. No response is issued and state returns to IDLE.
- req_valid while not ready is ignored. The core must hold the request.
- Back-to-back: a new request may be accepted the cycle after RESP. Maximum throughput is one request per 3 cycles (word) or 4 cycles (sub-word).

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state encoding localparams.
- One natural sub-module: lsu_load_align. Combinational byte/half select plus sign/zero extension from (word, addr[1:0], funct3). Reused by a future pipelined core.

Test Plan:
- Memory word 0 = 0xFACEFACE:
  - LB addr 0x1 → resp_rdata 0xFFFFFFFA, err 0, resp_valid 2 cycles after accept;
  - LBU addr 0x1 → 0x000000FA;
  - LHU addr 0x2 → 0x0000FACE.
- SB addr 0x2, wdata 0x12345677 on word 0xFACEFACE → exactly one mem_we pulse with mem_addr 0x0, mem_wd 0xFA77FACE; resp_valid 3 cycles after accept.
- SW addr 0x8, wdata 0xDEADBEEF → mem_we one cycle, mem_addr 0x8, mem_wd 0xDEADBEEF. A following LW addr 0x8 returns 0xDEADBEEF.
- Errors, each with no mem_we and resp_valid 1 cycle after accept with resp_err=1, rdata 0:
  - LW addr 0x6;
  - SH addr 0x3;
  - load funct3 011.
- Assert rst in the WRITE cycle of an SH → mem_we stays 0, no resp_valid, req_ready=1 next cycle, memory word unchanged.
- Hold req_valid continuously with alternating LW and SB → each accepted only when req_ready=1, responses in order, no request lost or duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: data width, RV32I funct3
// encodings for memory ops, FSM state type and the request legality check.
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    // Illegal funct3 or a halfword/word address that is not naturally aligned.
    function automatic logic req_is_err(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (we) begin
            illegal = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
        end else begin
            illegal = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                        (f3 == F3_BU) || (f3 == F3_HU));
        end
        misaligned = ((f3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_master_if
// Bundles the core-side request/response handshake and the data-memory port.
//   req_*  : request from the core (valid/ready, we, funct3, addr, wdata)
//   resp_* : one-cycle completion pulse with load data and error flag
//   mem_*  : word-aligned memory port, combinational read data in mem_rd
// Modports:
//   master : the load/store unit itself
//   slave  : the environment (core + data memory)
// -----------------------------------------------------------------------------
interface lsu_mem_master_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wd;
    logic [XLEN-1:0] mem_rd;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_addr, mem_wd
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_we, mem_addr, mem_wd
    );

endinterface

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load data alignment: picks the addressed byte/halfword out of
// a memory word and sign- or zero-extends it according to funct3.
//   i_word    : aligned memory word
//   i_addr_lo : byte offset within the word
//   i_funct3  : load funct3 (LB/LH/LW/LBU/LHU)
//   o_data    : extended result (0 for non-load encodings)
// -----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            F3_W:    o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
// Single-outstanding load/store initiator between the core memory stage and a
// word-addressed data memory. Sub-word stores use read-modify-write; illegal
// or misaligned requests respond with an error without touching memory.
//   clk : system clock
//   rst : synchronous active-high reset (aborts any transaction in flight)
//   bus : lsu_mem_master_if.master (request, response and memory port)
// -----------------------------------------------------------------------------
module lsu_mem_master
    import lsu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    lsu_mem_master_if.master        bus
);

    lsu_state_e      r_state;
    lsu_state_e      w_next;

    logic            r_we;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_merge;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic            w_accept;
    logic            w_req_err;
    logic [XLEN-1:0] w_aligned;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_merged;

    assign w_accept  = bus.req_valid && bus.req_ready;
    assign w_req_err = req_is_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign w_aligned = {r_addr[XLEN-1:2], 2'b00};

    lsu_load_align u_load_align (
        .i_word    (bus.mem_rd),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    // Store merge: replace only the addressed lane of the word read in RMW_RD.
    always_comb begin
        w_merged = r_merge;
        if (r_funct3 == F3_H) begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end else begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next = ST_RESP;
                    end else if (!bus.req_we) begin
                        w_next = ST_LOAD;
                    end else if (bus.req_funct3 == F3_W) begin
                        w_next = ST_WRITE;
                    end else begin
                        w_next = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD:   w_next = ST_RESP;
            ST_RMW_RD: w_next = ST_WRITE;
            ST_WRITE:  w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Request latch, merge word and response data.
    // resp_rdata only changes on the edge that enters RESP so it holds
    // the previous response's value while the next request is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= bus.req_we;
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_err    <= w_req_err;
                if (w_req_err) begin
                    r_rdata <= '0;
                end
            end
            if (r_state == ST_RMW_RD) begin
                r_merge <= bus.mem_rd;
            end
            if (r_state == ST_LOAD) begin
                r_rdata <= w_load_data;
            end
            if ((r_state == ST_WRITE) && r_we) begin
                r_rdata <= '0;
            end
        end
    end

    // Outputs; everything is forced inactive while rst is high so a write in
    // progress is dropped at the reset edge.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wd     = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: bus.req_ready = 1'b1;
                ST_LOAD, ST_RMW_RD: bus.mem_addr = w_aligned;
                ST_WRITE: begin
                    bus.mem_we   = 1'b1;
                    bus.mem_addr = w_aligned;
                    bus.mem_wd   = (r_funct3 == F3_W) ? r_wdata : w_merged;
                end
                ST_RESP: begin
                    bus.resp_valid = 1'b1;
                    bus.resp_err   = r_err;
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_rdata = r_rdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_master
// Directed vectors against lsu_mem_master with a 16-word behavioural memory.
// -----------------------------------------------------------------------------
module tb_lsu_mem_master;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_load = 1'b0;

    lsu_mem_master_if u_if ();

    lsu_mem_master u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.master)
    );

    always #5 clk = ~clk;

    logic [31:0] r_mem [0:15];

    assign u_if.mem_rd = r_mem[u_if.mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) r_mem[i] <= 32'h0;
            r_mem[0] <= 32'hFACEFACE;
        end else if (u_if.mem_we) begin
            r_mem[u_if.mem_addr[5:2]] <= u_if.mem_wd;
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
        int unsigned nwe;
        logic [31:0] waddr;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } b2b_t;

    task automatic drive(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        u_if.req_we     = we;
        u_if.req_funct3 = f3;
        u_if.req_addr   = addr;
        u_if.req_wdata  = wdata;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int unsigned lat;
        int unsigned nwe;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        lat = 0; nwe = 0; wa = '0; wd = '0; rd = '0; er = 1'b0;
        @(negedge clk);
        drive(v.we, v.f3, v.addr, v.wdata);
        u_if.req_valid = 1'b1;
        for (int k = 0; k < 20 && !u_if.req_ready; k++) @(negedge clk);
        @(negedge clk);
        u_if.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (u_if.mem_we) begin
                nwe++;
                wa = u_if.mem_addr;
                wd = u_if.mem_wd;
            end
            if (u_if.resp_valid) begin
                lat = k;
                rd  = u_if.resp_rdata;
                er  = u_if.resp_err;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d rdata", idx), rd, v.rdata);
        chk($sformatf("v%0d err", idx), {31'd0, er}, {31'd0, v.err});
        chk($sformatf("v%0d mem_we pulses", idx), nwe, v.nwe);
        if (v.nwe != 0) begin
            chk($sformatf("v%0d mem_addr", idx), wa, v.waddr);
            chk($sformatf("v%0d mem_wd", idx), wd, v.wd);
        end
        @(negedge clk);
        chk($sformatf("v%0d resp_valid one cycle", idx), {31'd0, u_if.resp_valid}, 32'd0);
        chk($sformatf("v%0d rdata held", idx), u_if.resp_rdata, v.rdata);
        chk($sformatf("v%0d idle mem_we", idx), {31'd0, u_if.mem_we}, 32'd0);
    endtask

    vec_t tbl [19];
    b2b_t bs [6];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned idx;
        int unsigned rn;
        bit          pend;

        u_if.req_valid = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);

        //          we    f3      addr          wdata         rdata         err  lat nwe waddr         wd
        tbl[0]  = '{1'b0, F3_B,  32'h00000001, 32'h00000000, 32'hFFFFFFFA, 1'b0, 2, 0, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, F3_BU, 32'h00000001, 32'h00000000, 32'h000000FA, 1'b0, 2, 0, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, F3_HU, 32'h00000002, 32'h00000000, 32'h0000FACE, 1'b0, 2, 0, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, F3_H,  32'h00000000, 32'h00000000, 32'hFFFFFACE, 1'b0, 2, 0, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, F3_W,  32'h00000000, 32'h00000000, 32'hFACEFACE, 1'b0, 2, 0, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, F3_B,  32'h00000002, 32'h12345677, 32'h00000000, 1'b0, 3, 1, 32'h00000000, 32'hFA77FACE};
        tbl[6]  = '{1'b0, F3_W,  32'h00000000, 32'h00000000, 32'hFA77FACE, 1'b0, 2, 0, 32'h0,        32'h0};
        tbl[7]  = '{1'b1, F3_W,  32'h00000008, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1, 32'h00000008, 32'hDEADBEEF};
        tbl[8]  = '{1'b0, F3_W,  32'h00000008, 32'h00000000, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0,        32'h0};
        tbl[9]  = '{1'b0, F3_W,  32'h00000006, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 32'h0,        32'h0};
        tbl[10] = '{1'b1, F3_H,  32'h00000003, 32'h0000BEEF, 32'h00000000, 1'b1, 1, 0, 32'h0,        32'h0};
        tbl[11] = '{1'b0, 3'b011, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 32'h0,       32'h0};
        tbl[12] = '{1'b1, 3'b100, 32'h00000000, 32'h000000AA, 32'h00000000, 1'b1, 1, 0, 32'h0,       32'h0};
        tbl[13] = '{1'b1, F3_H,  32'h00000002, 32'h0000BEEF, 32'h00000000, 1'b0, 3, 1, 32'h00000000, 32'hBEEFFACE};
        tbl[14] = '{1'b0, F3_H,  32'h00000002, 32'h00000000, 32'hFFFFBEEF, 1'b0, 2, 0, 32'h0,        32'h0};
        tbl[15] = '{1'b0, F3_B,  32'h00000003, 32'h00000000, 32'hFFFFFFBE, 1'b0, 2, 0, 32'h0,        32'h0};
        tbl[16] = '{1'b0, F3_BU, 32'h00000000, 32'h00000000, 32'h000000CE, 1'b0, 2, 0, 32'h0,        32'h0};
        tbl[17] = '{1'b1, F3_B,  32'h0000000D, 32'h000000AB, 32'h00000000, 1'b0, 3, 1, 32'h0000000C, 32'h0000AB00};
        tbl[18] = '{1'b0, F3_W,  32'h0000000C, 32'h00000000, 32'h0000AB00, 1'b0, 2, 0, 32'h0,        32'h0};

        bs[0] = '{1'b1, F3_B, 32'h00000010, 32'h00000011, 32'h00000000};
        bs[1] = '{1'b0, F3_W, 32'h00000010, 32'h00000000, 32'h00000011};
        bs[2] = '{1'b1, F3_B, 32'h00000011, 32'h00000022, 32'h00000000};
        bs[3] = '{1'b0, F3_W, 32'h00000010, 32'h00000000, 32'h00002211};
        bs[4] = '{1'b1, F3_B, 32'h00000013, 32'h00000044, 32'h00000000};
        bs[5] = '{1'b0, F3_W, 32'h00000010, 32'h00000000, 32'h44002211};

        // Reset state
        rst = 1'b1;
        mem_load = 1'b1;
        repeat (3) @(negedge clk);
        chk("req_ready in reset", {31'd0, u_if.req_ready}, 32'd0);
        rst = 1'b0;
        mem_load = 1'b0;
        #1;
        chk("reset req_ready", {31'd0, u_if.req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, u_if.resp_valid}, 32'd0);
        chk("reset resp_err", {31'd0, u_if.resp_err}, 32'd0);
        chk("reset resp_rdata", u_if.resp_rdata, 32'd0);
        chk("reset mem_we", {31'd0, u_if.mem_we}, 32'd0);
        chk("reset mem_addr", u_if.mem_addr, 32'd0);
        chk("reset mem_wd", u_if.mem_wd, 32'd0);

        for (int i = 0; i < 19; i++) run_vec(i, tbl[i]);

        // Reset asserted during the WRITE cycle of an SH
        @(negedge clk);
        drive(1'b1, F3_H, 32'h00000008, 32'h00001111);
        u_if.req_valid = 1'b1;
        @(negedge clk);
        u_if.req_valid = 1'b0;
        chk("rst-sh rmw mem_addr", u_if.mem_addr, 32'h00000008);
        @(negedge clk);
        chk("rst-sh write mem_we before rst", {31'd0, u_if.mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst-sh mem_we gated", {31'd0, u_if.mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst-sh req_ready", {31'd0, u_if.req_ready}, 32'd1);
        chk("rst-sh resp_valid", {31'd0, u_if.resp_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst-sh no response", {31'd0, u_if.resp_valid}, 32'd0);
        end
        chk("rst-sh memory unchanged", r_mem[2], 32'hDEADBEEF);
        run_vec(100, '{1'b0, F3_W, 32'h00000008, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0, 32'h0});

        // Back-to-back with req_valid held high
        idx = 0;
        rn = 0;
        @(negedge clk);
        drive(bs[0].we, bs[0].f3, bs[0].addr, bs[0].wdata);
        u_if.req_valid = 1'b1;
        pend = u_if.req_valid && u_if.req_ready;
        for (int c = 0; c < 100 && rn < 6; c++) begin
            @(negedge clk);
            if (u_if.resp_valid) begin
                chk($sformatf("b2b r%0d response after accept", rn), {31'd0, rn < idx}, 32'd1);
                chk($sformatf("b2b r%0d rdata", rn), u_if.resp_rdata, bs[rn].rdata);
                chk($sformatf("b2b r%0d err", rn), {31'd0, u_if.resp_err}, 32'd0);
                rn++;
            end
            if (pend) begin
                idx++;
                if (idx < 6) begin
                    drive(bs[idx].we, bs[idx].f3, bs[idx].addr, bs[idx].wdata);
                end else begin
                    u_if.req_valid = 1'b0;
                end
            end
            pend = u_if.req_valid && u_if.req_ready;
        end
        u_if.req_valid = 1'b0;
        chk("b2b responses", rn, 32'd6);
        chk("b2b accepts", idx, 32'd6);
        repeat (3) begin
            @(negedge clk);
            chk("b2b no extra response", {31'd0, u_if.resp_valid}, 32'd0);
        end
        chk("b2b memory word", r_mem[4], 32'h44002211);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
